jogo_memoria_param: RTL and testbench

Parametrised successor of the memory-challenge game core. It plays an N-button Simon-style game. Each round appends one pseudo-random element, generated by an LFSR seeded at game start, to an internal sequence memory. It then displays the whole sequence on the LEDs and checks the player's button presses against it, with a per-press timeout. The level input selects a target round count from four choices, and a malformed (multi-hot) press is detected as an error. The block sits under the board top-level, in the same position as the previous game core.

---
 rtl/jogo_memoria_pkg.sv | 29 ++
 rtl/jogo_memoria_param_gerador_lfsr.sv | 40 ++++
 rtl/jogo_memoria_param.sv | 184 ++++++++++++++++++
 tb/tb_jogo_memoria_param.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_memoria_pkg.sv
// Purpose : shared definitions for the parametrised memory-game core.
//           State encodings, LFSR feedback taps and the level -> target
//           round count mapping.
// Ports   : none (package).
package jogo_memoria_pkg;

  typedef enum logic [4:0] {
    INICIAL     = 5'd0,
    PREPARA     = 5'd1,
    GERA        = 5'd2,
    MOSTRA      = 5'd3,
    INTERVALO   = 5'd4,
    ESPERA      = 5'd5,
    REGISTRA    = 5'd6,
    COMPARA     = 5'd7,
    PROXIMA     = 5'd8,
    FIM_GANHOU  = 5'd9,
    FIM_PERDEU  = 5'd10,
    FIM_TIMEOUT = 5'd11
  } estado_t;

  localparam logic [15:0] LFSR_TAP = 16'hB400;

  // Number of rounds needed to win at the given level.
  function automatic int rodadas_alvo(input logic [1:0] nivel, input int max_rodadas);
    return (int'(nivel) + 1) * max_rodadas / 4;
  endfunction

endpackage

// File: rtl/jogo_memoria_param_gerador_lfsr.sv
// Purpose : 16-bit Galois LFSR (right shift) used as the sequence source.
// Ports   : clock_i    system clock
//           reset_i    synchronous active-high reset, clears the register
//           carrega_i  load semente_i (an all-zero seed is replaced by 1)
//           semente_i  seed value
//           avanca_i   advance one step
//           elemento_o top W_ELEM bits of the value after the next step,
//                      i.e. the element produced when avanca_i is taken
module gerador_lfsr
  import jogo_memoria_pkg::*;
#(
  parameter int W_ELEM = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              carrega_i,
  input  logic [15:0]       semente_i,
  input  logic              avanca_i,
  output logic [W_ELEM-1:0] elemento_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [15:0] proximo;

  assign proximo    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAP : 16'h0000);
  assign elemento_o = proximo[15 -: W_ELEM];

  always_comb begin
    lfsr_d = lfsr_q;
    if (carrega_i)     lfsr_d = (semente_i == 16'h0000) ? 16'h0001 : semente_i;
    else if (avanca_i) lfsr_d = proximo;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) lfsr_q <= 16'h0000;
    else         lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/jogo_memoria_param.sv
// Purpose : N-button Simon-style game core. Each round adds one LFSR
//           element to the sequence memory, displays the whole sequence
//           and checks the player's presses with a per-press timeout.
// Ports   : clock, reset (sync, active-high)
//           jogar        start/restart request (level)
//           nivel        level, target rounds = (nivel+1)*MAX_RODADAS/4
//           semente      LFSR seed, latched at game start
//           botoes       debounced buttons, active-high
//           leds         one-hot element during display, else 0
//           pronto/ganhou/perdeu/timeout  end-state flags
//           db_estado/db_rodada/db_contagem  debug views
//
// state       | meaning
// INICIAL     | idle after reset, waits for jogar
// PREPARA     | level/seed latched, round 0
// GERA        | one new element appended to the sequence
// MOSTRA      | element lit for T_LED cycles
// INTERVALO   | LEDs off for T_GAP cycles
// ESPERA      | waits for a press edge, bounded by T_TIMEOUT
// REGISTRA    | captured press settles
// COMPARA     | press checked against the expected element
// PROXIMA     | round index advances
// FIM_GANHOU  | won, waits for jogar
// FIM_PERDEU  | wrong press, waits for jogar
// FIM_TIMEOUT | no press in time, waits for jogar
module jogo_memoria_param
  import jogo_memoria_pkg::*;
#(
  parameter int N_BOTOES    = 4,
  parameter int MAX_RODADAS = 16,
  parameter int T_LED       = 1000,
  parameter int T_GAP       = 100,
  parameter int T_TIMEOUT   = 5000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           jogar,
  input  logic [1:0]                     nivel,
  input  logic [15:0]                    semente,
  input  logic [N_BOTOES-1:0]            botoes,
  output logic [N_BOTOES-1:0]            leds,
  output logic                           pronto,
  output logic                           ganhou,
  output logic                           perdeu,
  output logic                           timeout,
  output logic [4:0]                     db_estado,
  output logic [$clog2(MAX_RODADAS)-1:0] db_rodada,
  output logic [$clog2(MAX_RODADAS)-1:0] db_contagem
);

  localparam int RW   = $clog2(MAX_RODADAS);
  localparam int EW   = $clog2(N_BOTOES);
  localparam int TMAX = (T_TIMEOUT > T_LED) ? ((T_TIMEOUT > T_GAP) ? T_TIMEOUT : T_GAP)
                                            : ((T_LED > T_GAP) ? T_LED : T_GAP);
  localparam int TW   = $clog2(TMAX + 1);

  estado_t             estado_q, estado_d;
  logic [RW-1:0]       rodada_q, contagem_q, alvo_q;
  logic [N_BOTOES-1:0] jogada_q;
  logic                botoes_or_q;
  logic [TW-1:0]       tmr_q;
  logic [EW-1:0]       mem_q [MAX_RODADAS];

  logic [EW-1:0]       elemento;
  logic [N_BOTOES-1:0] esperado;
  logic                tmr_fim;
  logic                pressao;
  logic                correto;
  logic                fim;
  logic                inicio;

  assign fim      = (estado_q == FIM_GANHOU) || (estado_q == FIM_PERDEU) ||
                    (estado_q == FIM_TIMEOUT);
  assign inicio   = ((estado_q == INICIAL) || fim) && jogar;
  assign tmr_fim  = (tmr_q == '0);
  // Rising edge of "any button"; a button held across entry shows no edge.
  assign pressao  = (|botoes) && !botoes_or_q;
  assign esperado = {{(N_BOTOES-1){1'b0}}, 1'b1} << mem_q[contagem_q];
  // A multi-hot capture can never equal a one-hot value, so it fails here.
  assign correto  = (jogada_q == esperado);

  gerador_lfsr #(.W_ELEM(EW)) u_lfsr (
    .clock_i   (clock),
    .reset_i   (reset),
    .carrega_i (inicio),
    .semente_i (semente),
    .avanca_i  (estado_q == GERA),
    .elemento_o(elemento)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) estado_q <= INICIAL;
    else       estado_q <= estado_d;
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:     if (jogar) estado_d = PREPARA;
      PREPARA:     estado_d = GERA;
      GERA:        estado_d = MOSTRA;
      MOSTRA:      if (tmr_fim) estado_d = INTERVALO;
      INTERVALO:   if (tmr_fim) estado_d = (contagem_q == rodada_q) ? ESPERA : MOSTRA;
      ESPERA: begin
        if (pressao)      estado_d = REGISTRA;
        else if (tmr_fim) estado_d = FIM_TIMEOUT;
      end
      REGISTRA:    estado_d = COMPARA;
      COMPARA: begin
        if (!correto)                    estado_d = FIM_PERDEU;
        else if (contagem_q != rodada_q) estado_d = ESPERA;
        else if (rodada_q == alvo_q)     estado_d = FIM_GANHOU;
        else                             estado_d = PROXIMA;
      end
      PROXIMA:     estado_d = GERA;
      FIM_GANHOU,
      FIM_PERDEU,
      FIM_TIMEOUT: if (jogar) estado_d = PREPARA;
      default:     estado_d = INICIAL;
    endcase
  end

  // Outputs
  always_comb begin
    leds        = (estado_q == MOSTRA) ? esperado : '0;
    pronto      = fim;
    ganhou      = (estado_q == FIM_GANHOU);
    perdeu      = (estado_q == FIM_PERDEU);
    timeout     = (estado_q == FIM_TIMEOUT);
    db_estado   = estado_q;
    db_rodada   = rodada_q;
    db_contagem = contagem_q;
  end

  // Counters, timer and captured press
  always_ff @(posedge clock) begin
    if (reset) begin
      rodada_q    <= '0;
      contagem_q  <= '0;
      alvo_q      <= '0;
      jogada_q    <= '0;
      botoes_or_q <= 1'b0;
      tmr_q       <= '0;
    end else begin
      botoes_or_q <= |botoes;

      // Down-counter reloaded on every state entry, including re-entry
      // into ESPERA after each correct press.
      if (estado_d != estado_q) begin
        case (estado_d)
          MOSTRA:    tmr_q <= TW'(T_LED - 1);
          INTERVALO: tmr_q <= TW'(T_GAP - 1);
          ESPERA:    tmr_q <= TW'(T_TIMEOUT - 1);
          default:   tmr_q <= '0;
        endcase
      end else if (!tmr_fim) begin
        tmr_q <= tmr_q - 1'b1;
      end

      if (inicio) begin
        rodada_q   <= '0;
        contagem_q <= '0;
        alvo_q     <= RW'(rodadas_alvo(nivel, MAX_RODADAS) - 1);
      end

      case (estado_q)
        GERA:      contagem_q <= '0;
        INTERVALO: if (tmr_fim) contagem_q <= (contagem_q == rodada_q) ? '0 : contagem_q + 1'b1;
        ESPERA:    if (pressao) jogada_q <= botoes;
        COMPARA:   if (correto && (contagem_q != rodada_q)) contagem_q <= contagem_q + 1'b1;
        PROXIMA:   rodada_q <= rodada_q + 1'b1;
        default:   ;
      endcase
    end
  end

  // Sequence memory
  always_ff @(posedge clock) begin
    if (estado_q == GERA) mem_q[rodada_q] <= elemento;
  end

endmodule

// File: tb/tb_jogo_memoria_param.sv
module tb_jogo_memoria_param;

  localparam int N    = 4;
  localparam int MAXR = 16;
  localparam int TL   = 20;
  localparam int TG   = 5;
  localparam int TT   = 60;

  localparam logic [4:0] S_INICIAL = 5'd0;
  localparam logic [4:0] S_PREPARA = 5'd1;
  localparam logic [4:0] S_MOSTRA  = 5'd3;
  localparam logic [4:0] S_ESPERA  = 5'd5;
  localparam logic [4:0] S_COMPARA = 5'd7;
  localparam logic [4:0] S_PROXIMA = 5'd8;
  localparam logic [4:0] S_GANHOU  = 5'd9;
  localparam logic [4:0] S_PERDEU  = 5'd10;
  localparam logic [4:0] S_TIMEOUT = 5'd11;

  logic         clk = 1'b0;
  logic         reset, jogar;
  logic [1:0]   nivel;
  logic [15:0]  semente;
  logic [N-1:0] botoes, leds;
  logic         pronto, ganhou, perdeu, timeout;
  logic [4:0]   db_estado;
  logic [3:0]   db_rodada, db_contagem;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] exp_seq [MAXR];
  logic [N-1:0] sb_q [$];

  jogo_memoria_param #(
    .N_BOTOES(N), .MAX_RODADAS(MAXR), .T_LED(TL), .T_GAP(TG), .T_TIMEOUT(TT)
  ) dut (
    .clock(clk), .reset(reset), .jogar(jogar), .nivel(nivel), .semente(semente),
    .botoes(botoes), .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .timeout(timeout), .db_estado(db_estado), .db_rodada(db_rodada),
    .db_contagem(db_contagem)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic gen_seq(input logic [15:0] seed);
    logic [15:0] s;
    s = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int i = 0; i < MAXR; i++) begin
      s = lfsr_step(s);
      exp_seq[i] = 4'b0001 << s[15:14];
    end
  endtask

  task automatic start_game(input logic [15:0] seed, input logic [1:0] nv);
    @(negedge clk);
    semente = seed; nivel = nv; jogar = 1'b1;
    gen_seq(seed);
    @(negedge clk);
    jogar = 1'b0; semente = 16'hFFFF; nivel = ~nv;  // must already be latched
    total++;
    if (db_estado !== S_PREPARA) begin
      bad++; $display("FAIL start_state got=%0d want=%0d", db_estado, S_PREPARA);
    end
  endtask

  // Scoreboard: expected elements of round r are queued, then popped as
  // each one appears on the LEDs; on and off durations are measured.
  task automatic watch_display(input int r, output int dur);
    logic [N-1:0] v, e;
    int w, n, m;
    dur = 0;
    sb_q.delete();
    for (int i = 0; i <= r; i++) sb_q.push_back(exp_seq[i]);
    for (int i = 0; i <= r; i++) begin
      w = 0;
      while (leds === '0 && w < 200) begin @(negedge clk); w++; end
      if (w >= 200) begin
        total++; bad++;
        $display("FAIL display_wait round=%0d elem=%0d got=no_leds want=leds_on", r, i);
        return;
      end
      e = sb_q.pop_front();
      v = leds;
      total++;
      if (v !== e) begin
        bad++; $display("FAIL display_elem round=%0d elem=%0d got=%b want=%b", r, i, v, e);
      end
      n = 0;
      while (leds === v && n < TL + 10) begin n++; @(negedge clk); end
      total++;
      if (n != TL) begin
        bad++; $display("FAIL led_on_cycles round=%0d elem=%0d got=%0d want=%0d", r, i, n, TL);
      end
      m = 0;
      while (leds === '0 && db_estado !== S_ESPERA && m < TG + 10) begin m++; @(negedge clk); end
      total++;
      if (m != TG) begin
        bad++; $display("FAIL led_gap_cycles round=%0d elem=%0d got=%0d want=%0d", r, i, m, TG);
      end
      dur += n + m;
    end
    total++;
    if (db_estado !== S_ESPERA) begin
      bad++; $display("FAIL after_display round=%0d got=%0d want=%0d", r, db_estado, S_ESPERA);
    end
  endtask

  // Called at a negedge in ESPERA; press is sampled by the next posedge.
  task automatic press(input logic [N-1:0] v, input logic [4:0] want);
    botoes = v;
    @(negedge clk);
    botoes = '0;
    @(negedge clk);
    total++;
    if (db_estado !== S_COMPARA) begin
      bad++; $display("FAIL press_latency got=%0d want=%0d", db_estado, S_COMPARA);
    end
    @(negedge clk);
    total++;
    if (db_estado !== want) begin
      bad++; $display("FAIL press_verdict press=%b got=%0d want=%0d", v, db_estado, want);
    end
  endtask

  task automatic play_round(input int r, input bit last);
    int d;
    watch_display(r, d);
    for (int i = 0; i <= r; i++)
      press(exp_seq[i], (i < r) ? S_ESPERA : (last ? S_GANHOU : S_PROXIMA));
  endtask

  task automatic check_idle_outputs(input string nm);
    total++;
    if ({leds, pronto, ganhou, perdeu, timeout, db_estado, db_rodada, db_contagem} !== '0) begin
      bad++;
      $display("FAIL %s got=leds:%b flags:%b%b%b%b st:%0d rod:%0d cnt:%0d want=all_zero",
               nm, leds, pronto, ganhou, perdeu, timeout, db_estado, db_rodada, db_contagem);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; jogar = 1'b0; nivel = 2'd0; semente = 16'h0; botoes = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("reset_state");
    @(negedge clk);
    total++;
    if (db_estado !== S_INICIAL) begin
      bad++; $display("FAIL idle_hold got=%0d want=%0d", db_estado, S_INICIAL);
    end
  endtask

  task automatic test_win_level0();
    int d;
    start_game(16'h0001, 2'd0);
    play_round(0, 1'b0);
    play_round(1, 1'b0);
    watch_display(2, d);
    total++;
    if (d != 3 * (TL + TG)) begin
      bad++; $display("FAIL round3_display_len got=%0d want=%0d", d, 3 * (TL + TG));
    end
    for (int i = 0; i <= 2; i++) press(exp_seq[i], (i < 2) ? S_ESPERA : S_PROXIMA);
    play_round(3, 1'b1);
    total++;
    if ({ganhou, pronto, perdeu, timeout} !== 4'b1100 || db_rodada !== 4'd3) begin
      bad++; $display("FAIL win_l0 got=gpxt:%b%b%b%b rod:%0d want=gpxt:1100 rod:3",
                      ganhou, pronto, perdeu, timeout, db_rodada);
    end
    repeat (5) @(negedge clk);
    total++;
    if (ganhou !== 1'b1) begin
      bad++; $display("FAIL win_hold got=%b want=1", ganhou);
    end
  endtask

  task automatic test_wrong_press();
    int d;
    start_game(16'h0001, 2'd0);
    play_round(0, 1'b0);
    watch_display(1, d);
    press(4'b0100, S_ESPERA);
    press(4'b0001, S_PERDEU);
    total++;
    if ({perdeu, pronto, ganhou, timeout} !== 4'b1100) begin
      bad++; $display("FAIL wrong_flags got=pdgt:%b%b%b%b want=pdgt:1100", perdeu, pronto, ganhou, timeout);
    end
  endtask

  task automatic test_multihot();
    int d;
    start_game(16'h0001, 2'd0);
    watch_display(0, d);
    press(4'b0101, S_PERDEU);
    total++;
    if (perdeu !== 1'b1) begin
      bad++; $display("FAIL multihot got=%b want=1", perdeu);
    end
  endtask

  task automatic test_level3();
    start_game(16'h0001, 2'd3);
    for (int r = 0; r < MAXR; r++) play_round(r, r == MAXR - 1);
    total++;
    if (ganhou !== 1'b1 || db_rodada !== 4'(MAXR - 1)) begin
      bad++; $display("FAIL win_l3 got=g:%b rod:%0d want=g:1 rod:%0d", ganhou, db_rodada, MAXR - 1);
    end
  endtask

  task automatic test_timeout_held();
    int d, k;
    start_game(16'h0000, 2'd0);   // zero seed behaves as seed 1
    botoes = exp_seq[0];          // held through display and into ESPERA
    watch_display(0, d);
    k = 0;
    while (timeout !== 1'b1 && k < TT + 20) begin @(negedge clk); k++; end
    total++;
    if (k != TT) begin
      bad++; $display("FAIL timeout_cycles got=%0d want=%0d", k, TT);
    end
    total++;
    if ({timeout, pronto, perdeu, ganhou} !== 4'b1100 || db_estado !== S_TIMEOUT) begin
      bad++; $display("FAIL timeout_flags got=tpdg:%b%b%b%b st:%0d want=tpdg:1100 st:%0d",
                      timeout, pronto, perdeu, ganhou, db_estado, S_TIMEOUT);
    end
    botoes = '0;
  endtask

  task automatic test_reset_mid();
    int w;
    start_game(16'h1234, 2'd1);
    play_round(0, 1'b0);
    play_round(1, 1'b0);
    w = 0;
    while (leds === '0 && w < 200) begin @(negedge clk); w++; end
    total++;
    if (db_estado !== S_MOSTRA) begin
      bad++; $display("FAIL mid_reset_setup got=%0d want=%0d", db_estado, S_MOSTRA);
    end
    reset = 1'b1; jogar = 1'b1;   // reset must win over jogar
    @(negedge clk);
    reset = 1'b0; jogar = 1'b0;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    total++;
    if (db_estado !== S_INICIAL) begin
      bad++; $display("FAIL mid_reset_idle got=%0d want=%0d", db_estado, S_INICIAL);
    end
  endtask

  initial begin
    test_reset();
    test_win_level0();
    test_wrong_press();
    test_multihot();
    test_level3();
    test_timeout_held();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
